// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction buffer between the fetch stage and the issue scheduler. Fetch
// pushes one packet per cycle. Issue pops one packet per cycle when it is not
// stalled. A mispredict flush discards every buffered wrong-path packet.
//
// Packet layout (ENTRY_W = 65): {pred_taken[64], pc[63:32], instr[31:0]}
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   flush      mispredict flush; the queue is empty after the next edge
//   enq_valid  fetch presents a packet on enq_data
//   enq_data   packet from fetch
//   enq_ready  queue can accept a packet this cycle (not full)
//   deq_valid  head entry is valid (not empty)
//   deq_data   head packet, first-word fall-through
//   deq_ready  issue consumes the head this cycle
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally modulo DEPTH.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 65,
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               enq_valid,
   input  logic [ENTRY_W-1:0] enq_data,
   output logic               enq_ready,
   output logic               deq_valid,
   output logic [ENTRY_W-1:0] deq_data,
   input  logic               deq_ready,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic [CNT_W-1:0]   w_count_next;
   logic               w_clear;
   logic               w_enq_fire;
   logic               w_deq_fire;

   // Status outputs come from the count register only. No input feeds them, so
   // there is no combinational path from enq_valid or deq_ready to the
   // handshake outputs. For the same reason a full queue refuses a write even
   // in a cycle where it frees an entry.
   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign enq_ready = ~full;
   assign deq_valid = ~empty;
   assign count     = r_count;
   assign deq_data  = r_mem[r_rd_ptr];

   // Reset and flush override both handshakes, so neither a write nor a pointer
   // move happens in a clearing cycle.
   assign w_clear    = reset | flush;
   assign w_enq_fire = enq_valid & enq_ready & ~w_clear;
   assign w_deq_fire = deq_valid & deq_ready & ~w_clear;

   always_comb begin
      // NOTE: the default comes first so that every path assigns the signal
      // and no latch is inferred.
      w_count_next = r_count;
      case ({w_enq_fire, w_deq_fire})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples values from before the edge.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq_fire) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_deq_fire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_next;
      end
   end

   // NOTE: the storage array is deliberately left without a reset. Its contents
   // are meaningless while count says the entries are empty, and leaving out the
   // reset lets the array map onto plain flops or RAM.
   always_ff @(posedge clk) begin
      if (w_enq_fire) r_mem[r_wr_ptr] <= enq_data;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the issue scheduler; it replaces the single-entry fetch/issue pipeline register.
- Fetch pushes one packet per cycle (PC, instruction word, predicted-taken bit). Issue pops one packet per cycle when it is not stalled.
- Decouples fetch from transient issue stalls (RS busy, ROB full, LSQ full).
- Discards all buffered wrong-path packets on a branch mispredict flush.

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2
ENTRY_W, 65, packet width: {pred_taken[64], pc[63:32], instr[31:0]}
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
flush  input  1  mispredict flush; empties queue at next edge
enq_valid  input  1  fetch presents a packet on enq_data
enq_data  input  ENTRY_W  packet from fetch
enq_ready  output  1  queue can accept this cycle (= not full)
deq_valid  output  1  head entry valid (= not empty)
deq_data  output  ENTRY_W  head packet (first-word fall-through)
deq_ready  input  1  issue consumes head this cycle
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
Storage and pointers:
- Storage is a DEPTH x ENTRY_W register array.
- wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
- count is a separate register, not derived from the pointers.

Reset and flush:
- When reset or flush is high at a rising edge, wr_ptr, rd_ptr and count go to 0.
- After that edge: empty=1, full=0, deq_valid=0, enq_ready=1.
- Array contents are don't-care; deq_data is don't-care while deq_valid=0.
- Reset and flush override any enq or deq in the same cycle; no write and no pointer advance occur.

Handshakes:
- enq fires when enq_valid & enq_ready.
  - enq_data is written at wr_ptr.
  - wr_ptr increments.
- deq fires when deq_valid & deq_ready.
  - rd_ptr increments.
  - deq_ready while empty is ignored.

Output timing:
- deq_data = mem[rd_ptr], combinational from registered state.
- deq_valid, full, empty, enq_ready and count are combinational functions of the count register only. They do not depend on the enq_valid or deq_ready inputs, so there are no combinational paths from inputs to the ready/valid outputs.

Count update:
- enq only: +1.
- deq only: -1.
- Both: unchanged, and both pointers advance.

Latency and bypass:
- There is no empty bypass: a packet enqueued into an empty queue appears on deq_valid/deq_data the following cycle. Minimum latency is 1 cycle.
- When full, enq_ready=0 even if deq_ready=1 in the same cycle. A full queue does not accept a write in the same cycle it frees an entry.
- When count == 1 and enq and deq fire together, the head is consumed, the new entry becomes head next cycle, and deq_valid stays 1.

Ordering and integrity:
- Strict FIFO order.
- No packet is duplicated or dropped except by flush or reset.
- Wrap-around from index DEPTH-1 to 0 is seamless.

Interaction with the rest of the design:
- Fetch enable is driven from enq_ready, or from mispredict so fetch can redirect.
- Issue drives deq_ready = ~stall.
- flush is tied to the mispredict signal.
- A mispredict flush takes priority over a simultaneous fetch push of the redirected PC. Fetch re-presents that packet on the next cycle, which the fetch-enable gating guarantees.

Assertions for the verification engineer:
- count never exceeds DEPTH and never underflows.
- full and empty are never both 1.
- An enq while full, or a deq while empty, never alters state.

Test Plan:
1. Reset, then push 0x00000000/0x00500093, 0x00000004/0x00100113, 0x00000008/0x002081B3 on consecutive cycles with deq_ready=0 -> count 1,2,3; deq_valid rises the cycle after the first push; deq_data.pc=0x00000000. Then deq_ready=1 for 3 cycles -> pcs 0x0,0x4,0x8 in order; empty=1 afterwards.
2. Push 8 packets (pc 0x0..0x1C) with deq_ready=0 -> full=1, enq_ready=0. A 9th push with pc=0x20 is ignored (count stays 8). Drain -> pcs 0x0..0x1C exactly, 0x20 never appears.
3. Wrap-around with continuous enq_valid=1 and deq_ready=1 for 20 cycles, pcs incrementing by 4 -> count stays 1 after the first cycle; outputs are in order with no gaps across pointer wrap at index 7->0.
4. Fill with 5 entries, then assert flush together with enq_valid=1 (pc=0x100) and deq_ready=1 -> next cycle count=0, empty=1, deq_valid=0. A following push of pc=0x100 appears at the head one cycle later.
5. Full queue (8 entries) with enq_valid=1 and deq_ready=1 in the same cycle -> only deq fires; count becomes 7; next cycle enq succeeds and count returns to 8.
6. Assert reset mid-stream with 3 entries and an enq in flight -> all outputs return to reset values next cycle (count=0, empty=1, enq_ready=1); no stale pc is observed after reset is released.
